// File: rtl/sdram_pixel_writer.sv
// Pixel write queue for the SDRAM/VGA controller: buffers (x,y,RGB565) writes as
// (word address, data) entries and replays them one at a time, paced on sd_lock.
module sdram_pixel_writer #(
    parameter int unsigned AW      = 4,
    parameter int unsigned ACK_TMO = 3,
    parameter logic [21:0] FB_BASE = '0
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          px_valid,
    output logic          px_ready,
    input  logic [9:0]    px_x,
    input  logic [8:0]    px_y,
    input  logic [15:0]   px_rgb,
    output logic [21:0]   sd_address,
    output logic [15:0]   sd_data,
    output logic          sd_rdwr,
    output logic          sd_clk,
    input  logic          sd_lock,
    output logic [AW:0]   level,
    output logic [15:0]   drop_cnt
);

    localparam int unsigned DEPTH = 2 ** AW;
    localparam int unsigned TW    = $clog2(ACK_TMO + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, ACK, BUSY} state_t;

    state_t        state;
    logic [TW-1:0] tmo;
    logic [37:0]   mem [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic [AW:0]   level_next;
    logic [21:0]   px_addr;
    logic [37:0]   head;
    logic          on_screen;
    logic          empty;
    logic          accept;
    logic          push;
    logic          pop;

    assign level = wr_ptr - rd_ptr;

    always_comb begin
        // y*640 as y*512 + y*128
        px_addr    = FB_BASE + {4'b0, px_y, 9'b0} + {6'b0, px_y, 7'b0} + {12'b0, px_x};
        on_screen  = (px_x < 10'd640) && (px_y < 9'd480);
        empty      = (level == '0);
        pop        = (state == ACK) && sd_lock;
        // a pop frees a slot this cycle even though px_ready still shows full
        accept     = px_valid && (px_ready || pop);
        push       = accept && on_screen;
        level_next = level + (AW+1)'(push) - (AW+1)'(pop);
        head       = mem[rd_ptr[AW-1:0]];
    end

    always_ff @(posedge clock) begin
        if (push)
            mem[wr_ptr[AW-1:0]] <= {px_addr, px_rgb};
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            px_ready   <= 1'b0;
            drop_cnt   <= '0;
            state      <= IDLE;
            tmo        <= '0;
            sd_clk     <= 1'b0;
            sd_rdwr    <= 1'b0;
            sd_address <= '0;
            sd_data    <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop)
                rd_ptr <= rd_ptr + (AW+1)'(1);
            px_ready <= (level_next != (AW+1)'(DEPTH));
            if (accept && !on_screen && drop_cnt != '1)
                drop_cnt <= drop_cnt + 16'd1;

            sd_clk  <= 1'b0;
            sd_rdwr <= 1'b0;
            case (state)
                IDLE: begin
                    if (!empty && !sd_lock) begin
                        sd_address <= head[37:16];
                        sd_data    <= head[15:0];
                        sd_clk     <= 1'b1;
                        sd_rdwr    <= 1'b1;
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    tmo   <= '0;
                    state <= ACK;
                end
                ACK: begin
                    // no lock within the window: request lost, go back and re-issue the head
                    if (sd_lock)
                        state <= BUSY;
                    else if (tmo == TW'(ACK_TMO - 1))
                        state <= IDLE;
                    else
                        tmo <= tmo + TW'(1);
                end
                BUSY: begin
                    if (!sd_lock)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
